// File: rtl/core_host_seq.sv
// core_host_seq: host-side sequencer that preloads data memory, triggers the core, waits for done and streams results
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a run (sampled only in IDLE)
//   ld_valid/ld_data    : preload byte stream, accepted while ld_ready
//   mem_*               : external data-memory port (combinational read of mem_addr)
//   req/done            : one-cycle request to the core / completion from the core
//   res_valid/res_data  : result byte stream, advanced on res_ready
//   busy, timeout       : not-idle flag, sticky abort flag
//   cycles, run_done    : RUN-cycle count of the current/last run, end-of-run pulse
module core_host_seq #(
    parameter int AW       = 8,
    parameter int LOAD_LEN = 4,
    parameter int RES_BASE = 64,
    parameter int RES_LEN  = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic          req,
    input  logic          done,
    output logic          res_valid,
    output logic [7:0]    res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          timeout,
    output logic [15:0]   cycles,
    output logic          run_done
);
    typedef enum logic [2:0] {IDLE, LOAD, REQ, RUN, READ, FIN} state_t;
    state_t state, nxt;
    logic [AW-1:0] li, addr_q;
    logic [15:0] ri;
    logic [7:0] wd_q;
    logic ld_acc, res_acc, last_ld, last_res, tmo_hit;
    always_comb begin
        ld_acc      = state == LOAD && ld_valid;
        res_acc     = state == READ && res_ready;
        last_ld     = li == AW'(LOAD_LEN - 1);
        last_res    = ri == 16'(RES_LEN - 1);
        tmo_hit     = !done && cycles == 16'(TIMEOUT - 1);
        ld_ready    = state == LOAD;
        mem_wr_en   = ld_acc && !reset;
        req         = state == REQ && !reset;
        res_valid   = state == READ;
        res_data    = res_valid ? mem_rd_data : 8'h00;
        busy        = state != IDLE;
        run_done    = state == FIN;
        // address follows the active phase and otherwise holds the last value driven
        mem_addr    = state == LOAD ? li : state == READ ? AW'(RES_BASE + 32'(ri)) : addr_q;
        mem_wr_data = ld_acc ? ld_data : wd_q;
        nxt         = state;
        unique case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = ld_acc && last_ld ? REQ : LOAD;
            REQ:     nxt = RUN;
            RUN:     nxt = done ? READ : tmo_hit ? FIN : RUN;
            READ:    nxt = res_acc && last_res ? FIN : READ;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            li      <= '0;
            ri      <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            timeout <= 1'b0;
            cycles  <= '0;
        end else begin
            state  <= nxt;
            addr_q <= mem_addr;
            wd_q   <= mem_wr_data;
            if (state == IDLE && start) begin
                li      <= '0;
                timeout <= 1'b0;
            end
            if (ld_acc) li <= li + 1'b1;
            if (state == REQ) cycles <= '0;
            // done in the terminal-count cycle takes priority over the abort
            if (state == RUN) begin
                cycles <= cycles == 16'hFFFF ? cycles : cycles + 16'd1;
                if (done) ri <= '0;
                else if (tmo_hit) timeout <= 1'b1;
            end
            if (res_acc) ri <= ri + 16'd1;
        end
    end
endmodule

// File: tb/tb_core_host_seq.sv
// tb_core_host_seq: randomized directed bench for core_host_seq against a reference memory/run model
module tb_core_host_seq;
    localparam int TO = 16;
    localparam int RB = 254;
    localparam int RL = 3;
    localparam int LL = 4;
    logic clk = 0, reset = 1, start = 0, ld_valid = 0, res_ready = 0, done = 0;
    logic [7:0] ld_data = 0;
    logic ld_ready, mem_wr_en, req, res_valid, busy, timeout, run_done;
    logic [7:0] mem_addr, mem_wr_data, mem_rd_data, res_data;
    logic [15:0] cycles;
    logic [7:0] mem [256];
    logic [7:0] refm [256];
    int checks = 0, errors = 0;
    core_host_seq #(.AW(8), .LOAD_LEN(LL), .RES_BASE(RB), .RES_LEN(RL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .req(req), .done(done), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .busy(busy), .timeout(timeout), .cycles(cycles), .run_done(run_done)
    );
    always #5 clk = ~clk;
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic do_load(input bit use_pat);
        logic [6:0] pat = 7'b1011001;
        int n = 0, g = 0;
        logic v;
        while (n < LL) begin
            v = use_pat ? pat[g] : (g > 20 ? 1'b1 : 1'($urandom_range(0, 1)));
            ld_valid = v;
            ld_data = 8'($urandom);
            #1 chk("ld_ready", ld_ready, 1);
            chk("ld_wr_en", mem_wr_en, v);
            chk("ld_no_req", req, 0);
            if (v) begin
                chk("ld_addr", mem_addr, n);
                chk("ld_wdata", mem_wr_data, ld_data);
                refm[n] = ld_data;
                n++;
            end
            @(negedge clk);
            g++;
        end
        ld_valid = 0;
    endtask
    task automatic run(input int done_at, input int stall0, input bit use_pat, input bit poke);
        int k = 1, a, stalls;
        int exp_cyc = done_at <= TO ? done_at : TO;
        bit exp_to = done_at > TO;
        start = 1;
        #1 chk("idle_busy", busy, 0);
        @(negedge clk);
        start = 0;
        do_load(use_pat);
        #1 chk("req_pulse", req, 1);
        chk("req_busy", busy, 1);
        @(negedge clk);
        forever begin
            done = k == done_at;
            #1 chk("run_req_low", req, 0);
            chk("run_no_res", res_valid, 0);
            @(negedge clk);
            done = 0;
            if (k == done_at || k == TO) break;
            k++;
        end
        #1 chk("cycles", cycles, exp_cyc);
        chk("timeout", timeout, exp_to);
        if (exp_to) begin
            chk("to_run_done", run_done, 1);
            chk("to_no_res", res_valid, 0);
            @(negedge clk);
            #1 chk("to_idle", busy, 0);
            chk("to_sticky", timeout, 1);
        end else begin
            for (int i = 0; i < RL; i++) begin
                a = (RB + i) % 256;
                stalls = i == 0 ? stall0 : int'($urandom_range(0, 1));
                for (int s = 0; s <= stalls; s++) begin
                    res_ready = s == stalls;
                    if (poke) start = 1;
                    #1 chk("res_valid", res_valid, 1);
                    chk("res_addr", mem_addr, a);
                    chk("res_data", res_data, refm[a]);
                    chk("res_no_wr", mem_wr_en, 0);
                    @(negedge clk);
                    start = 0;
                end
                res_ready = 0;
            end
            #1 chk("run_done", run_done, 1);
            chk("fin_timeout", timeout, 0);
            @(negedge clk);
            #1 chk("end_busy", busy, 0);
            chk("end_run_done", run_done, 0);
            chk("cycles_hold", cycles, exp_cyc);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            refm[i] = mem[i];
        end
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1 chk("rst_ld_ready", ld_ready, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wr_data, 0);
        chk("rst_req", req, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_run_done", run_done, 0);
        @(negedge clk);
        run(10, 0, 0, 0);
        run(5, 0, 1, 0);
        run(3, 3, 0, 1);
        run(100, 0, 0, 0);
        run(TO, 1, 0, 0);
        run(100, 0, 0, 0);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1 chk("rst_clears_timeout", timeout, 0);
        chk("rst_clears_cycles", cycles, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        ld_valid = 1;
        ld_data = 8'h5A;
        reset = 1;
        #1 chk("rst_forces_wr_en", mem_wr_en, 0);
        @(negedge clk);
        reset = 0;
        ld_valid = 0;
        #1 chk("rst_load_idle", busy, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        do_load(0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1 chk("mid_run_cycles", cycles, 3);
        reset = 1;
        #1 chk("rst_forces_req", req, 0);
        @(negedge clk);
        reset = 0;
        #1 chk("rst_run_busy", busy, 0);
        chk("rst_run_cycles", cycles, 0);
        chk("rst_run_timeout", timeout, 0);
        chk("rst_run_req", req, 0);
        @(negedge clk);
        #1 chk("idle_stays", busy, 0);
        for (int r = 0; r < 6; r++) run(int'($urandom_range(1, TO + 4)), int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_host_seq.md
Name: core_host_seq

Overview:
- Host-side initiator for the CPU core's req/done handshake and its data memory port.
- Sequence per run:
  - preload data memory from an input stream;
  - pulse req to the core;
  - wait for done, bounded by a timeout;
  - stream a window of result bytes back out of data memory.
- Sits beside the core in the system/bench wrapper and drives the memory's external write/read port.

Parameters:
- AW, 8, data-memory address width.
- LOAD_LEN, 4, bytes preloaded at addresses 0..LOAD_LEN-1. Must be >= 1.
- RES_BASE, 64, first result address.
- RES_LEN, 2, result bytes read back. Must be >= 1.
- TIMEOUT, 4096, maximum RUN cycles before abort. Must be 1..65535.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- ld_valid  input  1  preload byte valid.
- ld_data  input  8  preload byte.
- ld_ready  output  1  preload byte accepted this cycle when ld_valid=1.
- mem_wr_en  output  1  data-memory write strobe.
- mem_addr  output  AW  data-memory address.
- mem_wr_data  output  8  data-memory write data.
- mem_rd_data  input  8  data-memory read data; combinational read of mem_addr.
- req  output  1  start request to the core.
- done  input  1  completion from the core.
- res_valid  output  1  result byte valid.
- res_data  output  8  result byte.
- res_ready  input  1  result consumer ready.
- busy  output  1  high in every state except IDLE.
- timeout  output  1  sticky abort flag.
- cycles  output  16  RUN-cycle count of the current/last run.
- run_done  output  1  one-cycle end-of-run pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0 (ld_ready, mem_wr_en, mem_addr, mem_wr_data, req, res_valid, res_data, busy, timeout, cycles, run_done).
- While reset=1, mem_wr_en and req are combinationally forced to 0.
- Reset mid-run: on the reset edge, return to IDLE; timeout and cycles are cleared; no further writes or req.

States: IDLE, LOAD, REQ, RUN, READ, FIN.
- IDLE:
  - start=1 -> LOAD; load index li=0; timeout cleared.
  - start is ignored in all other states.
- LOAD:
  - ld_ready=1.
  - When ld_valid=1: mem_wr_en=1, mem_addr=li, mem_wr_data=ld_data, li++.
  - Gap cycles (ld_valid=0) produce no write; li holds.
  - The accepted write with li=LOAD_LEN-1 -> REQ.
- REQ:
  - req=1 for exactly this one cycle; cycles cleared to 0 -> RUN.
  - done is ignored in REQ.
- RUN:
  - Every RUN cycle, cycles increments, saturating at 16'hFFFF.
  - done=1 -> READ with result index ri=0. The increment for that cycle is included, so done seen in the Nth RUN cycle gives cycles=N.
  - done=0 with pre-increment cycles==TIMEOUT-1 -> timeout=1 -> FIN.
  - done=1 in the terminal-count cycle: done wins; no timeout.
- READ:
  - mem_addr=(RES_BASE+ri) mod 2^AW; res_valid=1; res_data=mem_rd_data (combinational).
  - On res_valid & res_ready: ri++. Accepting ri=RES_LEN-1 -> FIN.
  - When res_ready=0, mem_addr and res_data hold stable.
- FIN: run_done=1 for one cycle -> IDLE.
- Hold rules:
  - cycles and timeout hold after FIN until the next REQ / start respectively.
  - mem_addr holds its last value in IDLE/REQ/RUN.
  - mem_wr_en=0 outside LOAD.
- Latency:
  - Last load accept -> req is 1 cycle.
  - done -> first res_valid is 1 cycle.
  - Last result accept -> run_done is 1 cycle.

Test Plan:
- Nominal run (defaults): load 8'h11,8'h22,8'h33,8'h44 with continuous ld_valid -> writes to addr 0..3 on 4 consecutive cycles; req high 1 cycle the next cycle. Core raises done in the 10th RUN cycle -> cycles=10, timeout=0. res stream = mem[64], mem[65]; run_done pulses the cycle after the second accept; busy=0 afterward.
- Preload gaps: ld_valid pattern 1,0,0,1,1,0,1 -> exactly 4 writes, to addresses 0,1,2,3, on the ld_valid=1 cycles only; no req before the 4th write.
- Result backpressure: res_ready low for 3 cycles on byte 0 -> res_valid=1, mem_addr=64 and res_data constant for those 3 cycles; advance to addr 65 only after the accept.
- Timeout: TIMEOUT=16, done held 0 -> after 16 RUN cycles timeout=1, cycles=16; no res_valid ever; run_done pulses 1 cycle later. Next start clears timeout.
- Tie case: TIMEOUT=16, done=1 in the 16th RUN cycle -> timeout=0, cycles=16, READ entered.
- Reset and ignored start:
  - reset=1 during RUN -> next cycle busy=0, req=0, cycles=0, timeout=0, state IDLE.
  - start pulsed while in READ -> no effect on the sequence.
  - RES_BASE=254, RES_LEN=3 -> addresses 254, 255, 0.
